// File: rtl/core_run_ctrl.sv
// core_run_ctrl: launches the core at a given PC, runs it until halt or watchdog, counts retired instructions, arbitrates data memory
//
// Ports:
//   CLK, rst_n                       clock, asynchronous active-low reset
//   start, start_addr                launch request and program entry PC
//   pc_load, pc_load_addr            one-cycle PC load pulse and captured entry PC
//   core_en                          core may execute/retire this cycle
//   instr_retire, core_halt          retire and halt-retire strobes from the core
//   halt, timeout, instr_count       run result: finished, finished by watchdog, dynamic count (saturating)
//   core_mem_we/addr/wdata           core data-memory request
//   host_req/we/addr/wdata, host_gnt host data-memory request and grant
//   mem_we, mem_addr, mem_wdata      arbitrated data-memory port
//
// Build option: define CORE_RUN_WATCHDOG_EN to add the RUN-cycle watchdog and forced stop.
module core_run_ctrl #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_addr,
    output logic              core_en,
    input  logic              instr_retire,
    input  logic              core_halt,
    output logic              halt,
    output logic              timeout,
    output logic [CNT_W-1:0]  instr_count,
    input  logic              core_mem_we,
    input  logic [ADDR_W-1:0] core_mem_addr,
    input  logic [DATA_W-1:0] core_mem_wdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state;
    logic   wd_fire;
`ifdef CORE_RUN_WATCHDOG_EN
    logic [CNT_W-1:0] wd;
    // halt retiring in the expiry cycle takes priority over the watchdog
    assign wd_fire = (state == RUN) && !core_halt && (wd == CNT_W'(TIMEOUT_CYCLES - 1));
    // counts RUN cycles only; every run enters through LOAD, where it restarts from 0
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) wd <= '0;
        else        wd <= (state == RUN) ? wd + 1'b1 : '0;
    end
`else
    assign wd_fire = 1'b0;
`endif
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc_load      <= 1'b0;
            pc_load_addr <= '0;
            core_en      <= 1'b0;
            halt         <= 1'b0;
            timeout      <= 1'b0;
            instr_count  <= '0;
        end else begin
            pc_load <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    state        <= LOAD;
                    pc_load      <= 1'b1;
                    pc_load_addr <= start_addr;
                    halt         <= 1'b0;
                    timeout      <= 1'b0;
                    instr_count  <= '0;
                end
                LOAD: begin
                    state   <= RUN;
                    core_en <= 1'b1;
                end
                RUN: begin
                    if (instr_retire && !(&instr_count)) instr_count <= instr_count + 1'b1;
                    if (core_halt || wd_fire) begin
                        state   <= DONE;
                        core_en <= 1'b0;
                        halt    <= 1'b1;
                        timeout <= wd_fire;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    // zero-latency arbitration: host only while the core is idle
    assign host_gnt  = host_req && (state == IDLE || state == DONE);
    assign mem_we    = host_gnt ? host_we : (state == RUN) && core_mem_we;
    assign mem_addr  = host_gnt ? host_addr : core_mem_addr;
    assign mem_wdata = host_gnt ? host_wdata : core_mem_wdata;
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: directed self-checking bench for core_run_ctrl
module tb_core_run_ctrl;
    logic        CLK = 1'b0;
    logic        rst_n, start, instr_retire, core_halt;
    logic [7:0]  start_addr;
    logic        pc_load, core_en, halt, timeout;
    logic [7:0]  pc_load_addr;
    logic [15:0] instr_count;
    logic        core_mem_we, host_req, host_we, host_gnt, mem_we;
    logic [7:0]  core_mem_addr, core_mem_wdata, host_addr, host_wdata, mem_addr, mem_wdata;
    logic        s_pc_load, s_core_en, s_halt, s_timeout, s_host_gnt, s_mem_we;
    logic [7:0]  s_pc_load_addr, s_mem_addr, s_mem_wdata;
    logic [3:0]  s_instr_count;
    int          n_chk = 0, n_pass = 0;

    always #5 CLK = ~CLK;

    core_run_ctrl #(.CNT_W(16), .TIMEOUT_CYCLES(50)) u_dut (
        .CLK(CLK), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .pc_load(pc_load), .pc_load_addr(pc_load_addr), .core_en(core_en),
        .instr_retire(instr_retire), .core_halt(core_halt), .halt(halt),
        .timeout(timeout), .instr_count(instr_count), .core_mem_we(core_mem_we),
        .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    core_run_ctrl #(.CNT_W(4), .TIMEOUT_CYCLES(15)) u_sat (
        .CLK(CLK), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .pc_load(s_pc_load), .pc_load_addr(s_pc_load_addr), .core_en(s_core_en),
        .instr_retire(instr_retire), .core_halt(core_halt), .halt(s_halt),
        .timeout(s_timeout), .instr_count(s_instr_count), .core_mem_we(core_mem_we),
        .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(s_host_gnt), .mem_we(s_mem_we),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // start pulse, then land in the first RUN cycle
    task automatic launch(input logic [7:0] a);
        start = 1'b1; start_addr = a;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc_load"}, pc_load, 0);
        check({tag, "_pc_addr"}, pc_load_addr, 0);
        check({tag, "_core_en"}, core_en, 0);
        check({tag, "_halt"}, halt, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_count"}, instr_count, 0);
        check({tag, "_host_gnt"}, host_gnt, 0);
        check({tag, "_mem_we"}, mem_we, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = '0; instr_retire = 1'b0; core_halt = 1'b0;
        core_mem_we = 1'b0; core_mem_addr = '0; core_mem_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        step(2);
        check_all_zero("rst");
        rst_n = 1'b1;
        step();
        // host owns the port while idle
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'd127; host_wdata = 8'hA5;
        core_mem_addr = 8'd3; core_mem_wdata = 8'h11; core_mem_we = 1'b1;
        #1;
        check("idle_gnt", host_gnt, 1);
        check("idle_we", mem_we, 1);
        check("idle_addr", mem_addr, 127);
        check("idle_wdata", mem_wdata, 8'hA5);
        host_req = 1'b0;
        #1;
        check("idle_nogrant_we", mem_we, 0);
        check("idle_nogrant_addr", mem_addr, 3);
        core_mem_we = 1'b0;
        step();
        // launch at 75
        start = 1'b1; start_addr = 8'd75;
        step();
        start = 1'b0; start_addr = 8'd9;
        check("load_pulse", pc_load, 1);
        check("load_addr", pc_load_addr, 75);
        check("load_core_en", core_en, 0);
        step();
        check("run_pulse_gone", pc_load, 0);
        check("run_core_en", core_en, 1);
        // host denied during RUN, core drives memory
        host_req = 1'b1;
        #1;
        check("run_gnt", host_gnt, 0);
        check("run_we_core0", mem_we, 0);
        check("run_addr", mem_addr, 3);
        check("run_wdata", mem_wdata, 8'h11);
        core_mem_we = 1'b1;
        #1;
        check("run_we_core1", mem_we, 1);
        host_req = 1'b0; core_mem_we = 1'b0;
        // 37 retires with a stray start in the middle
        instr_retire = 1'b1;
        step(20);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ignored_pc_load", pc_load, 0);
        check("start_ignored_core_en", core_en, 1);
        check("start_ignored_count", instr_count, 21);
        step(16);
        check("count_37", instr_count, 37);
        core_halt = 1'b1;
        step();
        core_halt = 1'b0; instr_retire = 1'b0;
        check("halt_set", halt, 1);
        check("halt_count", instr_count, 38);
        check("halt_timeout", timeout, 0);
        check("halt_core_en", core_en, 0);
        // DONE is stable, retires are ignored
        instr_retire = 1'b1;
        step(3);
        instr_retire = 1'b0;
        check("done_count", instr_count, 38);
        check("done_halt", halt, 1);
        // start and host request together in DONE
        start = 1'b1; host_req = 1'b1; host_we = 1'b1;
        #1;
        check("done_gnt", host_gnt, 1);
        step();
        start = 1'b0;
        check("load_gnt", host_gnt, 0);
        check("load_mem_we", mem_we, 0);
        check("relaunch_pulse", pc_load, 1);
        check("relaunch_halt", halt, 0);
        check("relaunch_count", instr_count, 0);
        host_req = 1'b0; host_we = 1'b0;
        step();
        check("relaunch_core_en", core_en, 1);
`ifdef CORE_RUN_WATCHDOG_EN
        step(49);
        check("wd_before", halt, 0);
        step();
        check("wd_halt", halt, 1);
        check("wd_timeout", timeout, 1);
        check("wd_core_en", core_en, 0);
        launch(8'd1);
        step(49);
        core_halt = 1'b1;
        step();
        core_halt = 1'b0;
        check("wd_tie_halt", halt, 1);
        check("wd_tie_timeout", timeout, 0);
`else
        step(60);
        check("nowd_halt", halt, 0);
        check("nowd_core_en", core_en, 1);
        core_halt = 1'b1;
        step();
        core_halt = 1'b0;
        check("nowd_end_halt", halt, 1);
        check("nowd_end_timeout", timeout, 0);
`endif
        // asynchronous reset mid-run
        launch(8'd200);
        instr_retire = 1'b1;
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        instr_retire = 1'b0;
        check_all_zero("midrst");
        step();
        rst_n = 1'b1;
        step();
        // saturation on the 4-bit counter
        launch(8'd5);
        instr_retire = 1'b1;
        step(20);
        core_halt = 1'b1;
        step();
        core_halt = 1'b0; instr_retire = 1'b0;
        check("sat_count", s_instr_count, 15);
        check("sat_halt", s_halt, 1);
        check("wide_count", instr_count, 21);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
